// File: rtl/rom_upload_if.sv
// rom_upload_if: bundle of the ioctl upload handshake and the ROM RAM read side.
//
// master: host/ROM environment. Drives the ioctl request and returns ROM RAM
//         read data.
// slave : the readback engine (rom_upload). Drives the ROM read address and
//         select and answers the ioctl request.
//
// Signals:
//   ioctl_upload   upload session active
//   ioctl_rd       one-cycle byte request
//   ioctl_addr     byte address, sampled with ioctl_rd
//   ioctl_din      returned byte
//   ioctl_wait     high while a request is in progress
//   rom_addr       read address to the ROM RAMs (PROMs use [8:0])
//   rom_sel        one-hot select {ep1,ep2,ep3,ep4,ep5,cp1,cp2,cp3}
//   ep1_q..ep5_q   EPROM read data
//   cp1_q..cp3_q   colour PROM read data (4 bits)
//   csum           running checksum, only with ROM_UPLOAD_CSUM_EN defined
interface rom_upload_if;
   logic        ioctl_upload;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic [14:0] rom_addr;
   logic [7:0]  rom_sel;
   logic [7:0]  ep1_q;
   logic [7:0]  ep2_q;
   logic [7:0]  ep3_q;
   logic [7:0]  ep4_q;
   logic [7:0]  ep5_q;
   logic [3:0]  cp1_q;
   logic [3:0]  cp2_q;
   logic [3:0]  cp3_q;
`ifdef ROM_UPLOAD_CSUM_EN
   logic [15:0] csum;
`endif

   modport master (
      output ioctl_upload, ioctl_rd, ioctl_addr,
      output ep1_q, ep2_q, ep3_q, ep4_q, ep5_q, cp1_q, cp2_q, cp3_q,
`ifdef ROM_UPLOAD_CSUM_EN
      input  csum,
`endif
      input  ioctl_din, ioctl_wait, rom_addr, rom_sel
   );

   modport slave (
      input  ioctl_upload, ioctl_rd, ioctl_addr,
      input  ep1_q, ep2_q, ep3_q, ep4_q, ep5_q, cp1_q, cp2_q, cp3_q,
`ifdef ROM_UPLOAD_CSUM_EN
      output csum,
`endif
      output ioctl_din, ioctl_wait, rom_addr, rom_sel
   );
endinterface

// File: rtl/rom_upload.sv
// rom_upload: readback engine for the ROM image in the download-clock domain.
//
// Serves ioctl upload requests by reading one byte from the read port of the
// five 32 KiB EPROM RAMs or three 512-entry colour PROM RAMs. Address map:
//   0x00000-0x27FFF  EPROM 1..5 (32 KiB each)
//   0x28000-0x285FF  colour PROM 1..3 (512 nibbles each, zero-extended)
// Addresses at or above IMG_LEN select nothing and return 8'h00.
//
// Parameters:
//   RD_LAT   ROM RAM read latency in cycles, legal 1..3
//   IMG_LEN  image length in bytes
//
// Ports:
//   CLK_DL   download clock
//   RST_N    asynchronous active-low reset
//   bus      rom_upload_if.slave (ioctl handshake + ROM RAM read side)
//
// Optional feature: define ROM_UPLOAD_CSUM_EN to add the 16-bit wrap-around
// checksum of every returned byte on bus.csum, cleared on each rising edge of
// ioctl_upload.
//
// Timing (request in cycle T): T+1 wait high with rom_addr/rom_sel valid,
// ioctl_din valid and wait low at T+2+RD_LAT; a new request is accepted in
// that same cycle.
module rom_upload #(
   parameter int unsigned RD_LAT  = 1,
   parameter int unsigned IMG_LEN = 'h28600
) (
   input logic         CLK_DL,
   input logic         RST_N,
   rom_upload_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StFetch, StResp} state_e;

   localparam logic [1:0] LatInit = 2'(RD_LAT);

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        wait_q, wait_d;
   logic [14:0] addr_q, addr_d;
   logic [7:0]  sel_q, sel_d;
   logic [7:0]  din_q, din_d;

   logic        req;
   logic [31:0] addr_ext;
   logic [7:0]  sel_dec;
   logic [7:0]  rd_byte;

   assign req      = bus.ioctl_upload & bus.ioctl_rd;
   assign addr_ext = {7'd0, bus.ioctl_addr};

   // Region decode of the incoming request address.
   always_comb begin
      sel_dec = 8'h00;
      if (addr_ext < IMG_LEN) begin
         if (addr_ext < 32'h0000_8000) begin
            sel_dec = 8'h80;
         end else if (addr_ext < 32'h0001_0000) begin
            sel_dec = 8'h40;
         end else if (addr_ext < 32'h0001_8000) begin
            sel_dec = 8'h20;
         end else if (addr_ext < 32'h0002_0000) begin
            sel_dec = 8'h10;
         end else if (addr_ext < 32'h0002_8000) begin
            sel_dec = 8'h08;
         end else if (addr_ext < 32'h0002_8200) begin
            sel_dec = 8'h04;
         end else if (addr_ext < 32'h0002_8400) begin
            sel_dec = 8'h02;
         end else if (addr_ext < 32'h0002_8600) begin
            sel_dec = 8'h01;
         end
      end
   end

   // Read data mux; an all-zero select (out of range) yields 8'h00.
   always_comb begin
      rd_byte = 8'h00;
      unique case (sel_q)
         8'h80:   rd_byte = bus.ep1_q;
         8'h40:   rd_byte = bus.ep2_q;
         8'h20:   rd_byte = bus.ep3_q;
         8'h10:   rd_byte = bus.ep4_q;
         8'h08:   rd_byte = bus.ep5_q;
         8'h04:   rd_byte = {4'h0, bus.cp1_q};
         8'h02:   rd_byte = {4'h0, bus.cp2_q};
         8'h01:   rd_byte = {4'h0, bus.cp3_q};
         default: rd_byte = 8'h00;
      endcase
   end

   // State register.
   always_ff @(posedge CLK_DL or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= StIdle;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. The counter is loaded with RD_LAT when the address is
   // issued and reaches 0 in the cycle the RAM output becomes valid (RESP).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               state_d = StFetch;
               cnt_d   = LatInit;
            end
         end
         StFetch: begin
            if (!bus.ioctl_upload) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 2'd1;
               if (cnt_q == 2'd1) begin
                  state_d = StResp;
               end
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output next-state logic; every output is registered.
   always_comb begin
      wait_d = wait_q;
      addr_d = addr_q;
      sel_d  = sel_q;
      din_d  = din_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               wait_d = 1'b1;
               addr_d = bus.ioctl_addr[14:0];
               sel_d  = sel_dec;
            end
         end
         StFetch: begin
            // Abort: drop the request but keep the last returned byte.
            if (!bus.ioctl_upload) begin
               wait_d = 1'b0;
               sel_d  = 8'h00;
            end
         end
         StResp: begin
            din_d  = rd_byte;
            wait_d = 1'b0;
            sel_d  = 8'h00;
         end
         default: begin
            wait_d = 1'b0;
            sel_d  = 8'h00;
         end
      endcase
   end

   always_ff @(posedge CLK_DL or negedge RST_N) begin
      if (!RST_N) begin
         wait_q <= 1'b0;
         addr_q <= 15'd0;
         sel_q  <= 8'h00;
         din_q  <= 8'h00;
      end else begin
         wait_q <= wait_d;
         addr_q <= addr_d;
         sel_q  <= sel_d;
         din_q  <= din_d;
      end
   end

   assign bus.ioctl_din  = din_q;
   assign bus.ioctl_wait = wait_q;
   assign bus.rom_addr   = addr_q;
   assign bus.rom_sel    = sel_q;

`ifdef ROM_UPLOAD_CSUM_EN
   logic        upload_q;
   logic [15:0] csum_q, csum_d;
   logic        resp_fire;

   assign resp_fire = (state_q == StResp);

   // Session start clears; only completed responses are accumulated, so an
   // aborted fetch never touches the sum.
   always_comb begin
      csum_d = csum_q;
      if (bus.ioctl_upload && !upload_q) begin
         csum_d = 16'h0000;
      end else if (resp_fire) begin
         csum_d = csum_q + {8'h00, rd_byte};
      end
   end

   always_ff @(posedge CLK_DL or negedge RST_N) begin
      if (!RST_N) begin
         upload_q <= 1'b0;
         csum_q   <= 16'h0000;
      end else begin
         upload_q <= bus.ioctl_upload;
         csum_q   <= csum_d;
      end
   end

   assign bus.csum = csum_q;
`endif

endmodule

// File: tb/tb_rom_upload.sv
// Self-checking bench for rom_upload. A flat byte-array image stands in for
// the ROM RAMs (with RD_LAT cycles of read latency); expected bytes and
// selects are derived from the address map with plain arithmetic.
module tb_rom_upload;

   localparam int unsigned LAT     = 1;
   localparam int unsigned IMG_LEN = 'h28600;

   logic clk;
   logic rst_n;
   logic force_ff;
   int   checks;
   int   errors;

   logic [7:0]  img [0:'h285FF];
   logic [14:0] ap  [LAT];

   rom_upload_if bus ();

   rom_upload #(
      .RD_LAT  (LAT),
      .IMG_LEN (IMG_LEN)
   ) dut (
      .CLK_DL (clk),
      .RST_N  (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM RAM model: address pipeline of LAT stages, data read from the image.
   always @(posedge clk) begin
      ap[0] <= bus.rom_addr;
      for (int i = 1; i < int'(LAT); i++) ap[i] <= ap[i-1];
   end

   always_comb begin
      logic [14:0] a;
      logic [8:0]  p;
      a = ap[LAT-1];
      p = a[8:0];
      bus.ep1_q = force_ff ? 8'hFF : img[32'h00000 + 32'(a)];
      bus.ep2_q = force_ff ? 8'hFF : img[32'h08000 + 32'(a)];
      bus.ep3_q = force_ff ? 8'hFF : img[32'h10000 + 32'(a)];
      bus.ep4_q = force_ff ? 8'hFF : img[32'h18000 + 32'(a)];
      bus.ep5_q = force_ff ? 8'hFF : img[32'h20000 + 32'(a)];
      bus.cp1_q = force_ff ? 4'hF : img[32'h28000 + 32'(p)][3:0];
      bus.cp2_q = force_ff ? 4'hF : img[32'h28200 + 32'(p)][3:0];
      bus.cp3_q = force_ff ? 4'hF : img[32'h28400 + 32'(p)][3:0];
   end

   function automatic logic [7:0] ref_byte(input logic [24:0] a);
      int unsigned ai;
      ai = a;
      if (ai >= IMG_LEN) return 8'h00;
      if (force_ff) return (ai < 'h28000) ? 8'hFF : 8'h0F;
      return img[ai];
   endfunction

   function automatic logic [7:0] ref_sel(input logic [24:0] a);
      int unsigned ai;
      int unsigned region;
      ai = a;
      if (ai >= IMG_LEN) return 8'h00;
      if (ai < 'h28000) region = ai / 'h8000;
      else region = 5 + (ai - 'h28000) / 512;
      return 8'h80 >> region;
   endfunction

   // Issue one request at the current negedge (DUT must be idle) and follow it
   // to completion. Returns at the negedge where ioctl_wait has fallen.
   task automatic do_read(input logic [24:0] a, input string tag);
      logic [7:0] exp_din;
      logic [7:0] exp_sel;
      int         waits;
      exp_din = ref_byte(a);
      exp_sel = ref_sel(a);
      bus.ioctl_rd   = 1'b1;
      bus.ioctl_addr = a;
      @(negedge clk);
      bus.ioctl_rd = 1'b0;
      checks++;
      if (bus.ioctl_wait !== 1'b1 || bus.rom_sel !== exp_sel || bus.rom_addr !== a[14:0]) begin
         errors++;
         $display("FAIL %s issue addr=%h: wait=%b sel=%h rom_addr=%h, want wait=1 sel=%h rom_addr=%h",
                  tag, a, bus.ioctl_wait, bus.rom_sel, bus.rom_addr, exp_sel, a[14:0]);
      end
      waits = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.ioctl_wait !== 1'b1) break;
         waits++;
      end
      checks++;
      if (waits != int'(LAT) + 1) begin
         errors++;
         $display("FAIL %s latency addr=%h: wait cycles=%0d, want %0d", tag, a, waits, LAT + 1);
      end
      checks++;
      if (bus.ioctl_din !== exp_din || bus.rom_sel !== 8'h00 || bus.ioctl_wait !== 1'b0) begin
         errors++;
         $display("FAIL %s data addr=%h: din=%h sel=%h wait=%b, want din=%h sel=00 wait=0",
                  tag, a, bus.ioctl_din, bus.rom_sel, bus.ioctl_wait, exp_din);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.ioctl_din !== 8'h00 || bus.ioctl_wait !== 1'b0 || bus.rom_addr !== 15'h0
          || bus.rom_sel !== 8'h00) begin
         errors++;
         $display("FAIL reset: din=%h wait=%b rom_addr=%h sel=%h, want all zero",
                  bus.ioctl_din, bus.ioctl_wait, bus.rom_addr, bus.rom_sel);
      end
`ifdef ROM_UPLOAD_CSUM_EN
      checks++;
      if (bus.csum !== 16'h0) begin
         errors++;
         $display("FAIL reset_csum: csum=%h, want 0000", bus.csum);
      end
`endif
      rst_n            = 1'b1;
      bus.ioctl_upload = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      img['h00005] = 8'hA5;
      do_read(25'h00005, "basic_ep1");
   endtask

   task automatic test_boundaries;
      img['h285FF] = 8'h0C;
      do_read(25'h27FFF, "bound_ep5_top");
      do_read(25'h28000, "bound_cp1_base");
      do_read(25'h285FF, "bound_cp3_top");
      checks++;
      if (bus.ioctl_din !== 8'h0C) begin
         errors++;
         $display("FAIL bound_cp3_value: din=%h, want 0c", bus.ioctl_din);
      end
      do_read(25'h07FFF, "bound_ep1_top");
      do_read(25'h08000, "bound_ep2_base");
      do_read(25'h28200, "bound_cp2_base");
   endtask

   task automatic test_out_of_range;
      force_ff = 1'b1;
      do_read(25'h28600, "oor_first");
      do_read(25'h1FFFFFF, "oor_max");
      do_read(25'h00123, "ff_ep1");
      force_ff = 1'b0;
   endtask

   task automatic test_random;
      logic [24:0] a;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 9))
            0:       a = 25'($urandom_range('h28600, 'h1FFFFFF));
            1:       a = 25'('h28000 + $urandom_range(0, 'h5FF));
            default: a = 25'($urandom_range(0, 'h285FF));
         endcase
         do_read(a, "random");
      end
   endtask

   task automatic test_back_to_back;
      // do_read returns in the cycle wait falls; the next call issues at once.
      img['h10010] = 8'h3C;
      img['h18020] = 8'hC3;
      do_read(25'h10010, "b2b_first");
      do_read(25'h18020, "b2b_second");
      checks++;
      if (bus.ioctl_din !== 8'hC3) begin
         errors++;
         $display("FAIL b2b_value: din=%h, want c3", bus.ioctl_din);
      end
   endtask

   task automatic test_ignored_rd;
      logic [24:0] a;
      logic [7:0]  exp_din;
      a = 25'h20456;
      img[a] = 8'h77;
      exp_din = 8'h77;
      bus.ioctl_rd = 1'b1;
      bus.ioctl_addr = a;
      @(negedge clk);
      bus.ioctl_addr = 25'h00999;  // stays high through FETCH and RESP
      @(negedge clk);
      bus.ioctl_rd = 1'b0;
      checks++;
      if (bus.rom_addr !== a[14:0]) begin
         errors++;
         $display("FAIL ignore_addr: rom_addr=%h, want %h", bus.rom_addr, a[14:0]);
      end
      @(negedge clk);
      checks++;
      if (bus.ioctl_wait !== 1'b0 || bus.ioctl_din !== exp_din) begin
         errors++;
         $display("FAIL ignore_resp: wait=%b din=%h, want 0 %h", bus.ioctl_wait, bus.ioctl_din, exp_din);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (bus.ioctl_wait !== 1'b0 || bus.rom_addr !== a[14:0]) begin
            errors++;
            $display("FAIL ignore_single: wait=%b rom_addr=%h, want 0 %h",
                     bus.ioctl_wait, bus.rom_addr, a[14:0]);
         end
      end
      // Request without an upload session.
      bus.ioctl_upload = 1'b0;
      bus.ioctl_rd = 1'b1;
      bus.ioctl_addr = 25'h00321;
      @(negedge clk);
      bus.ioctl_rd = 1'b0;
      checks++;
      if (bus.ioctl_wait !== 1'b0 || bus.rom_sel !== 8'h00 || bus.rom_addr !== a[14:0]) begin
         errors++;
         $display("FAIL no_upload: wait=%b sel=%h rom_addr=%h, want 0 00 %h",
                  bus.ioctl_wait, bus.rom_sel, bus.rom_addr, a[14:0]);
      end
      bus.ioctl_upload = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_abort;
      logic [7:0] prev;
      img['h0ABCD] = 8'h5A;
      do_read(25'h0ABCD, "abort_prep");
      prev = 8'h5A;
      img['h1ABCD] = 8'hA5;
      bus.ioctl_rd = 1'b1;
      bus.ioctl_addr = 25'h1ABCD;
      @(negedge clk);
      bus.ioctl_rd = 1'b0;
      bus.ioctl_upload = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ioctl_wait !== 1'b0 || bus.rom_sel !== 8'h00 || bus.ioctl_din !== prev) begin
         errors++;
         $display("FAIL abort: wait=%b sel=%h din=%h, want 0 00 %h",
                  bus.ioctl_wait, bus.rom_sel, bus.ioctl_din, prev);
      end
      @(negedge clk);
      checks++;
      if (bus.ioctl_din !== prev || bus.ioctl_wait !== 1'b0) begin
         errors++;
         $display("FAIL abort_hold: din=%h wait=%b, want %h 0", bus.ioctl_din, bus.ioctl_wait, prev);
      end
      bus.ioctl_upload = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_fetch;
      img['h04444] = 8'hEE;
      do_read(25'h04444, "rst_prep");
      bus.ioctl_rd = 1'b1;
      bus.ioctl_addr = 25'h12345;
      @(negedge clk);
      bus.ioctl_rd = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.ioctl_wait !== 1'b0 || bus.ioctl_din !== 8'h00 || bus.rom_sel !== 8'h00
          || bus.rom_addr !== 15'h0) begin
         errors++;
         $display("FAIL reset_mid_fetch: wait=%b din=%h sel=%h rom_addr=%h, want all zero",
                  bus.ioctl_wait, bus.ioctl_din, bus.rom_sel, bus.rom_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_read(25'h12345, "after_reset");
   endtask

`ifdef ROM_UPLOAD_CSUM_EN
   task automatic test_csum;
      bus.ioctl_upload = 1'b0;
      @(negedge clk);
      bus.ioctl_upload = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.csum !== 16'h0000) begin
         errors++;
         $display("FAIL csum_clear: csum=%h, want 0000", bus.csum);
      end
      img['h00010] = 8'hFF;
      img['h00011] = 8'hFF;
      img['h00012] = 8'h02;
      do_read(25'h00010, "csum_b0");
      do_read(25'h00011, "csum_b1");
      do_read(25'h00012, "csum_b2");
      checks++;
      if (bus.csum !== 16'h0200) begin
         errors++;
         $display("FAIL csum_sum: csum=%h, want 0200", bus.csum);
      end
      bus.ioctl_upload = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.csum !== 16'h0200) begin
         errors++;
         $display("FAIL csum_hold: csum=%h, want 0200", bus.csum);
      end
      bus.ioctl_upload = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.csum !== 16'h0000) begin
         errors++;
         $display("FAIL csum_restart: csum=%h, want 0000", bus.csum);
      end
   endtask
`endif

   initial begin
      checks           = 0;
      errors           = 0;
      rst_n            = 1'b0;
      force_ff         = 1'b0;
      bus.ioctl_upload = 1'b0;
      bus.ioctl_rd     = 1'b0;
      bus.ioctl_addr   = 25'h0;
      for (int i = 0; i < int'(IMG_LEN); i++) begin
         img[i] = (i < 'h28000) ? 8'($urandom) : {4'h0, 4'($urandom)};
      end
      test_reset();
      test_basic();
      test_boundaries();
      test_out_of_range();
      test_random();
      test_back_to_back();
      test_ignored_rd();
      test_abort();
      test_reset_mid_fetch();
`ifdef ROM_UPLOAD_CSUM_EN
      test_csum();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rom_upload.md
# rom_upload

Readback engine for the ROM image in the download-clock domain. Serves HPS ioctl upload requests by reading bytes from the read ports of the five 32 KiB EPROM RAMs and three 512-entry colour PROM RAMs, so the host can dump or verify the loaded image. It uses the same address map as the download path: EPROMs 1–5 at 0x00000–0x27FFF, colour PROMs 1–3 at 0x28000–0x285FF. It sits beside the loader on `CLK_DL` and owns the `*_b` read side of each ROM RAM while `ioctl_upload` is high.

## Interface
- `RD_LAT`, default 1: ROM RAM read latency in cycles. Legal values are 1–3.
- `IMG_LEN`, default 'h28600: image length in bytes. Addresses at or above this value are out of range.

Ports:
- `CLK_DL`, in, 1: single clock, the download clock.
- `RST_N`, in, 1: reset, asynchronous, active-low.
- `ioctl_upload`, in, 1: upload session active.
- `ioctl_rd`, in, 1: one-cycle byte request.
- `ioctl_addr`, in, 25: byte address, sampled with `ioctl_rd`.
- `ioctl_din`, out, 8: returned byte.
- `ioctl_wait`, out, 1: high while a request is in progress.
- `rom_addr`, out, 15: read address to the ROM RAMs. The PROMs use `[8:0]`.
- `rom_sel`, out, 8: one-hot select, bit order {ep1,ep2,ep3,ep4,ep5,cp1,cp2,cp3}, MSB = ep1.
- `ep1_q` … `ep5_q`, in, 8 each: EPROM read data.
- `cp1_q` … `cp3_q`, in, 4 each: PROM read data.
- `csum`, out, 16: running checksum. Present only with the macro defined.

## Operation
- FSM states: IDLE, FETCH, RESP.
- IDLE
  - Condition: `ioctl_upload & ioctl_rd`.
  - Action: latch the address; drive `rom_addr` from `ioctl_addr[14:0]`; decode `rom_sel` by the region boundaries above.
  - Set the latency counter to `RD_LAT`, set `ioctl_wait`=1, go to FETCH.
- FETCH
  - Decrement the counter each cycle.
  - At 0: capture the muxed data by `rom_sel`. PROM nibbles are zero-extended ({4'h0,q}).
  - Go to RESP.
- RESP
  - Drive the captured byte onto `ioctl_din`.
  - Set `ioctl_wait`=0, `rom_sel`=0, return to IDLE.
- Out-of-range address (≥ `IMG_LEN`): `rom_sel`=0. Same state sequence and latency; returns 8'h00.
- `ioctl_rd` while in FETCH or RESP: ignored. No queueing, no state change.
- `ioctl_rd` while `ioctl_upload`=0: ignored.
- `ioctl_upload` falling while in FETCH: abort to IDLE next cycle.
  - `ioctl_wait`=0 and `rom_sel`=0.
  - `ioctl_din` keeps its previous value.
  - The checksum is not updated.
- `rom_sel` and `rom_addr` are registered, and `rom_addr` holds its value after return to IDLE.

## Timing
- Request sampled at edge T.
  - T+1: `ioctl_wait`=1; `rom_addr` and `rom_sel` valid.
  - T+1+`RD_LAT`: data captured.
  - T+2+`RD_LAT`: `ioctl_din` valid, `ioctl_wait`=0.
  - With `RD_LAT`=1, `ioctl_din` is valid 3 cycles after `ioctl_rd`.
- Back-to-back: the next `ioctl_rd` is accepted in the cycle `ioctl_wait` falls (IDLE).
- Reset values, all asynchronous on `RST_N` low:
  - `ioctl_din`=0, `ioctl_wait`=0, `rom_addr`=0, `rom_sel`=0, `csum`=0.
  - State = IDLE.
- `RST_N` asserted mid-fetch: all outputs drop to their reset values immediately.

## Configuration
- Macro `ROM_UPLOAD_CSUM_EN`.
- Defined:
  - `csum` port present: a 16-bit wrap-around sum of every byte returned in RESP.
  - Cleared to 0 on the rising edge of `ioctl_upload`.
  - Holds its value after the upload ends.
- Undefined: no `csum` port and no accumulator logic. Everything else is identical.

## Test plan
- Reset with `RST_N`=0 mid-FETCH → `ioctl_wait`=0, `ioctl_din`=0, `rom_sel`=0 in the same cycle.
- `RD_LAT`=1, read 0x00005 with `ep1_q`=8'hA5 → `rom_sel`=8'h80, `rom_addr`=15'h0005, `ioctl_din`=8'hA5 at T+3, `ioctl_wait` high T+1..T+2 only.
- Reads at 0x27FFF, 0x28000, 0x285FF → `rom_sel` = 8'h08, 8'h04, 8'h01. With `cp3_q`=4'hC, `ioctl_din`=8'h0C.
- Read 0x28600 with all q=8'hFF → `rom_sel`=0, `ioctl_din`=8'h00, latency unchanged.
- Second `ioctl_rd` during FETCH → ignored, exactly one response. `ioctl_upload` dropped during FETCH → IDLE next cycle, `ioctl_din` unchanged.
- `ROM_UPLOAD_CSUM_EN`: upload bytes FF,FF,02 → `csum`=16'h0200. Restarting the upload clears it to 0.
